// File: rtl/weight_fifo_bank_pkg.sv
// Shared constants and types for the weight FIFO bank and its load controller.
package weight_fifo_bank_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_FIFO_WIDTH = 16;
    localparam int unsigned COUNT_WIDTH        = $clog2(DEFAULT_FIFO_WIDTH) + 1;

    typedef enum logic {
        ModeBypass,
        ModeStagger
    } load_mode_e;

    // Occupancy counter width for a given depth; must be able to hold the value depth itself.
    function automatic int unsigned count_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/weight_fifo_bank_if.sv
// Load-side and array-side signals of the weight FIFO bank.
interface weight_fifo_bank_if
    import weight_fifo_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_WIDTH = DEFAULT_FIFO_WIDTH
);

    logic [FIFO_WIDTH-1:0]            fifo_en;
    logic                             stagger_load;
    logic                             clear;
    logic [FIFO_WIDTH*DATA_WIDTH-1:0] weight_in;
    logic [FIFO_WIDTH*DATA_WIDTH-1:0] weight_out;
    logic [FIFO_WIDTH-1:0]            col_full;
    logic                             all_full;
    logic                             busy;

    modport master (
        output fifo_en, stagger_load, clear, weight_in,
        input  weight_out, col_full, all_full, busy
    );

    modport slave (
        input  fifo_en, stagger_load, clear, weight_in,
        output weight_out, col_full, all_full, busy
    );

endinterface

// File: rtl/weight_fifo_column.sv
// One column's shift-register FIFO with a saturating occupancy count.
module weight_fifo_column
    import weight_fifo_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full
);

    localparam int unsigned CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= '0;
            end
        end else if (shift) begin
            entry_q[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                entry_q[k] <= entry_q[k-1];
            end
        end
    end

    // Shifting while full drops the oldest word and leaves the count pinned at DEPTH.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = shift ? CW'(1) : '0;
        end else if (shift && (count_q != FULL_COUNT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign dout = entry_q[DEPTH-1];
    assign full = (count_q == FULL_COUNT);

endmodule

// File: rtl/weight_fifo_bank.sv
// Bank of per-column weight FIFOs with an optional triangular skew network on the load side.
module weight_fifo_bank
    import weight_fifo_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_WIDTH = DEFAULT_FIFO_WIDTH
) (
    input logic               clk,
    input logic               reset,
    weight_fifo_bank_if.slave bus
);

    logic                  prev_active_q;
    logic                  burst_start;
    load_mode_e            mode_q;
    load_mode_e            mode_d;
    logic                  stagger_sel;
    logic [FIFO_WIDTH-1:0] en_eff;
    logic [DATA_WIDTH-1:0] data_eff [FIFO_WIDTH];
    logic [FIFO_WIDTH-1:0] skew_any;
    logic [FIFO_WIDTH-1:0] col_full;

    assign burst_start = (|bus.fifo_en) && !prev_active_q;

    always_comb begin
        mode_d = mode_q;
        if (burst_start) begin
            mode_d = bus.stagger_load ? ModeStagger : ModeBypass;
        end
    end

    // Using mode_d routes the very first word of a burst by the fresh request.
    assign stagger_sel = (mode_d == ModeStagger);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q        <= ModeBypass;
            prev_active_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            prev_active_q <= |bus.fifo_en;
        end
    end

    for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_col
        logic [DATA_WIDTH-1:0] win;
        logic [DATA_WIDTH-1:0] dout;

        assign win = bus.weight_in[i*DATA_WIDTH +: DATA_WIDTH];

        if (i == 0) begin : g_direct
            assign en_eff[i]   = bus.fifo_en[i];
            assign data_eff[i] = win;
            assign skew_any[i] = 1'b0;
        end else begin : g_skew
            logic [i-1:0]          sen_q;
            logic [DATA_WIDTH-1:0] sdata_q [i];

            // Delay line runs in both modes; only the select decides whether it is used.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sen_q <= '0;
                    for (int k = 0; k < i; k++) begin
                        sdata_q[k] <= '0;
                    end
                end else begin
                    sen_q[0]   <= bus.fifo_en[i];
                    sdata_q[0] <= win;
                    for (int k = 1; k < i; k++) begin
                        sen_q[k]   <= sen_q[k-1];
                        sdata_q[k] <= sdata_q[k-1];
                    end
                end
            end

            assign en_eff[i]   = stagger_sel ? sen_q[i-1]   : bus.fifo_en[i];
            assign data_eff[i] = stagger_sel ? sdata_q[i-1] : win;
            assign skew_any[i] = |sen_q;
        end

        weight_fifo_column #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_WIDTH)
        ) u_column (
            .clk   (clk),
            .reset (reset),
            .clear (bus.clear),
            .shift (en_eff[i]),
            .din   (data_eff[i]),
            .dout  (dout),
            .full  (col_full[i])
        );

        assign bus.weight_out[i*DATA_WIDTH +: DATA_WIDTH] = dout;
    end

    assign bus.col_full = col_full;
    assign bus.all_full = &col_full;
    assign bus.busy     = (|bus.fifo_en) || (|skew_any);

endmodule

// File: tb/tb_weight_fifo_bank.sv
// Scoreboard bench for weight_fifo_bank at FIFO_WIDTH=4, DATA_WIDTH=8.
module tb_weight_fifo_bank;

    localparam int DW = 8;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic reset;

    weight_fifo_bank_if #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW)) bus ();

    weight_fifo_bank #(
        .DATA_WIDTH (DW),
        .FIFO_WIDTH (FW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // bsy < 0 or col < 0 means that field is not checked.
    typedef struct {
        int            cyc;
        logic [FW-1:0] full;
        logic          allf;
        int            bsy;
        int            col;
        logic [DW-1:0] word;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    function automatic logic [DW-1:0] wout(int c);
        return bus.weight_out[c*DW +: DW];
    endfunction

    task automatic expect_at(int c, logic [FW-1:0] f, logic a, int b, int col, logic [DW-1:0] w);
        exp_q.push_back('{cyc: c, full: f, allf: a, bsy: b, col: col, word: w});
    endtask

    task automatic drive(logic [FW-1:0] en, logic stag, logic clr, logic [FW*DW-1:0] win);
        bus.fifo_en      = en;
        bus.stagger_load = stag;
        bus.clear        = clr;
        bus.weight_in    = win;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic check_leftover(string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: %0d expectations unchecked, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        drive('0, 1'b0, 1'b0, '0);
        cyc = 0;
        for (int c = 0; c < FW; c++) expect_at(2, 4'b0000, 1'b0, 0, c, 8'h00);
        expect_at(3, 4'b0000, 1'b0, 0, -1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            reset = (k < 2);
            step();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.col_full !== e.full || bus.all_full !== e.allf
                    || (e.bsy >= 0 && bus.busy !== e.bsy[0])
                    || (e.col >= 0 && wout(e.col) !== e.word)) begin
                    n_fail++;
                    $display("FAIL reset cyc=%0d got full=%b all=%b busy=%b w%0d=%h want full=%b all=%b busy=%0d w=%h",
                             cyc, bus.col_full, bus.all_full, bus.busy, e.col,
                             (e.col >= 0) ? wout(e.col) : 8'h00, e.full, e.allf, e.bsy, e.word);
                end
            end
        end
        check_leftover("reset");
    endtask

    task automatic test_no_stagger();
        logic [FW*DW-1:0] w;
        do_reset();
        expect_at(3, 4'b0000, 1'b0, 1, -1, 8'h00);
        for (int c = 0; c < FW; c++) expect_at(4, 4'b1111, 1'b1, 1, c, DW'(16 * c));
        expect_at(8, 4'b1111, 1'b1, 0, 2, 8'h20);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < FW; c++) w[c*DW +: DW] = DW'(16 * c + k);
            drive((k < 4) ? 4'hF : 4'h0, 1'b0, 1'b0, w);
            step();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.col_full !== e.full || bus.all_full !== e.allf
                    || (e.bsy >= 0 && bus.busy !== e.bsy[0])
                    || (e.col >= 0 && wout(e.col) !== e.word)) begin
                    n_fail++;
                    $display("FAIL no_stagger cyc=%0d got full=%b all=%b busy=%b w%0d=%h want full=%b all=%b busy=%0d w=%h",
                             cyc, bus.col_full, bus.all_full, bus.busy, e.col,
                             (e.col >= 0) ? wout(e.col) : 8'h00, e.full, e.allf, e.bsy, e.word);
                end
            end
        end
        check_leftover("no_stagger");
    endtask

    // With toggle set, stagger_load drops after the burst-start cycle and must be ignored.
    task automatic test_stagger(bit toggle);
        logic [FW*DW-1:0] w;
        string name;
        name = toggle ? "stagger_toggle" : "stagger";
        do_reset();
        expect_at(3, 4'b0000, 1'b0, 1, -1, 8'h00);
        expect_at(4, 4'b0001, 1'b0, 1, 0, 8'h80);
        expect_at(5, 4'b0011, 1'b0, 1, -1, 8'h00);
        expect_at(6, 4'b0111, 1'b0, 1, -1, 8'h00);
        expect_at(7, 4'b1111, 1'b1, 0, 3, 8'hB0);
        expect_at(8, 4'b1111, 1'b1, 0, 1, 8'h90);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < FW; c++) w[c*DW +: DW] = DW'(8'h80 + 16 * c + k);
            if (k < 4) drive(4'hF, !(toggle && k >= 1), 1'b0, w);
            else       drive(4'h0, 1'b0, 1'b0, '0);
            step();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.col_full !== e.full || bus.all_full !== e.allf
                    || (e.bsy >= 0 && bus.busy !== e.bsy[0])
                    || (e.col >= 0 && wout(e.col) !== e.word)) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got full=%b all=%b busy=%b w%0d=%h want full=%b all=%b busy=%0d w=%h",
                             name, cyc, bus.col_full, bus.all_full, bus.busy, e.col,
                             (e.col >= 0) ? wout(e.col) : 8'h00, e.full, e.allf, e.bsy, e.word);
                end
            end
        end
        check_leftover(name);
    endtask

    task automatic test_single_col();
        do_reset();
        expect_at(6, 4'b0001, 1'b0, 1, 0, 8'h03);
        expect_at(7, 4'b0000, 1'b0, 1, 0, 8'h04);
        expect_at(9, 4'b0000, 1'b0, 1, -1, 8'h00);
        expect_at(10, 4'b0001, 1'b0, 1, 0, 8'h07);
        expect_at(11, 4'b0000, 1'b0, 0, 0, 8'h07);
        for (int k = 0; k < 11; k++) begin
            drive((k < 10) ? 4'b0001 : 4'b0000, 1'b0, (k == 6 || k == 10),
                  {24'h0, DW'(k + 1)});
            step();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.col_full !== e.full || bus.all_full !== e.allf
                    || (e.bsy >= 0 && bus.busy !== e.bsy[0])
                    || (e.col >= 0 && wout(e.col) !== e.word)) begin
                    n_fail++;
                    $display("FAIL single_col cyc=%0d got full=%b all=%b busy=%b w%0d=%h want full=%b all=%b busy=%0d w=%h",
                             cyc, bus.col_full, bus.all_full, bus.busy, e.col,
                             (e.col >= 0) ? wout(e.col) : 8'h00, e.full, e.allf, e.bsy, e.word);
                end
            end
        end
        check_leftover("single_col");
    endtask

    task automatic test_reset_mid_burst();
        logic [FW*DW-1:0] w;
        do_reset();
        for (int c = 0; c < FW; c++) expect_at(3, 4'b0000, 1'b0, 0, c, 8'h00);
        expect_at(6, 4'b0000, 1'b0, 0, -1, 8'h00);
        expect_at(8, 4'b0000, 1'b0, 0, 3, 8'h00);
        expect_at(12, 4'b0001, 1'b0, 1, 0, 8'h60);
        expect_at(15, 4'b1111, 1'b1, 0, 3, 8'h90);
        for (int k = 0; k < 15; k++) begin
            for (int c = 0; c < FW; c++) w[c*DW +: DW] = DW'(8'h60 + 16 * c + (k % 8));
            reset = (k == 2);
            if (k < 2)                drive(4'hF, 1'b1, 1'b0, {4{8'h55}});
            else if (k >= 8 && k < 12) drive(4'hF, 1'b1, 1'b0, w);
            else                       drive(4'h0, 1'b0, 1'b0, '0);
            step();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.col_full !== e.full || bus.all_full !== e.allf
                    || (e.bsy >= 0 && bus.busy !== e.bsy[0])
                    || (e.col >= 0 && wout(e.col) !== e.word)) begin
                    n_fail++;
                    $display("FAIL reset_mid_burst cyc=%0d got full=%b all=%b busy=%b w%0d=%h want full=%b all=%b busy=%0d w=%h",
                             cyc, bus.col_full, bus.all_full, bus.busy, e.col,
                             (e.col >= 0) ? wout(e.col) : 8'h00, e.full, e.allf, e.bsy, e.word);
                end
            end
        end
        reset = 1'b0;
        check_leftover("reset_mid_burst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        drive('0, 1'b0, 1'b0, '0);
        test_reset();
        test_no_stagger();
        test_stagger(1'b0);
        test_stagger(1'b1);
        test_single_col();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
